fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and flag controller for the 8-entry, 10-bit FIFO memory: the writer/reader side that drives the memory's `write_enable`, `write_addr`, `read_enable` and `read_addr`. It accepts push/pop requests from producer and consumer logic and tracks occupancy. It produces full/empty/almost flags, a read-data-valid strobe and a sticky overflow/underflow error. It contains no storage; data flows directly between the producer/consumer and the memory's `Fifo_Data_in`/`Fifo_Data_out`.

## Interface
- `MEM_LENGHT`, default 8: number of memory entries; must be a power of 2 and at most 16.
- `ADDR_WIDTH`, default 4: width of the memory address ports.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `push` input 1: producer requests a write of the current `Fifo_Data_in` this cycle.
- `pop` input 1: consumer requests a read this cycle.
- `almost_full_th` input 4: almost-full threshold, in entries.
- `almost_empty_th` input 4: almost-empty threshold, in entries.
- `write_enable` output 1: memory write strobe.
- `write_addr` output ADDR_WIDTH: memory write address.
- `read_enable` output 1: memory read strobe.
- `read_addr` output ADDR_WIDTH: memory read address.
- `data_valid` output 1: `Fifo_Data_out` holds popped data this cycle.
- `full` output 1: occupancy == MEM_LENGHT.
- `empty` output 1: occupancy == 0.
- `almost_full` output 1: occupancy >= `almost_full_th`.
- `almost_empty` output 1: occupancy <= `almost_empty_th`.
- `occupancy` output 5: current number of stored entries, 0..MEM_LENGHT.
- `fifo_error` output 1: sticky flag for overflow or underflow.

## Operation
- **State registers**
  - `wr_ptr` and `rd_ptr`: log2(MEM_LENGHT) bits each. Unused upper address bits are driven to 0.
  - `count`: 5 bits; drives `occupancy` directly.
  - `fifo_error`: 1 bit.
  - `data_valid`: 1 bit.
- **Acceptance**
  - A push is accepted when `push && !full`.
  - A pop is accepted when `pop && !empty`.
  - Acceptance is evaluated against the flags registered before the edge.
  - A push on full is rejected, even if a pop is accepted in the same cycle. A pop on empty is rejected, even if a push is accepted in the same cycle. This avoids same-address read/write hazards.
- **Memory strobes** (combinational from request inputs and registered flags)
  - `write_enable` = push accepted; `write_addr` = `wr_ptr`.
  - `read_enable` = pop accepted; `read_addr` = `rd_ptr`.
  - Both strobes are forced to 0 while `reset` is high.
- **Pointer update**
  - Each accepted operation increments its own pointer modulo MEM_LENGHT, so the pointer wraps from MEM_LENGHT-1 to 0.
- **Count update**
  - Push only: +1.
  - Pop only: −1.
  - Both accepted, or neither: unchanged.
- **Flags** are decoded from `count` only; they never depend on `push`/`pop` directly.
- **Threshold edge cases**
  - `almost_full_th` = 0: `almost_full` is constantly 1.
  - `almost_empty_th` >= MEM_LENGHT: `almost_empty` is constantly 1.
- **Error flag**
  - Set on the edge following a rejected push (overflow) or a rejected pop (underflow).
  - Cleared only by `reset`.
  - Rejected requests do not change pointers or `count`.
- **Reset values**
  - Pointers = 0, `count` = 0.
  - `empty` = 1, `full` = 0, `almost_full` = 0 (with `almost_full_th` > 0).
  - `almost_empty` = 1, `fifo_error` = 0, `data_valid` = 0.
  - `write_addr` = 0, `read_addr` = 0.

## Timing
- **Write**
  - Data on `Fifo_Data_in` is written at the edge that ends the cycle in which `write_enable` = 1.
  - `count` and the flags reflect the write one cycle after `push` is sampled.
- **Read**
  - The memory read is registered, so latency is 1 cycle.
  - `data_valid` = `read_enable` delayed by one clock; the consumer samples `Fifo_Data_out` when `data_valid` = 1.
- **Throughput**
  - One push and one pop per cycle is sustainable whenever 0 < `count` < MEM_LENGHT.
- **Flag timing**
  - `empty` deasserts on the edge after the first accepted push.
  - The earliest a pop can be accepted is the cycle after that push (no fall-through).
  - `full` asserts on the edge where `count` reaches MEM_LENGHT.
- **Reset mid-operation**
  - Asynchronous assertion clears all state and outputs within the same cycle.
  - An in-flight `data_valid` is dropped.
  - Memory contents are not cleared and are ignored afterwards.
  - The first push after release writes address 0.

## Test plan
- **Reset**: assert `reset` mid-stream with `count` = 5 → immediately `empty` = 1, `occupancy` = 0, `write_addr` = `read_addr` = 0, both enables 0, `data_valid` = 0.
- **Fill**: 8 consecutive pushes of 0x001..0x008 → `write_addr` steps 0..7. `almost_full` (th = 6) rises after the 6th push; `full` = 1 after the 8th. A 9th push gives `write_enable` = 0, `count` stays 8, and `fifo_error` = 1 the next cycle.
- **Drain**: from full, 8 consecutive pops → `read_addr` steps 0..7. `data_valid` follows each pop by one cycle with `Fifo_Data_out` = 0x001..0x008. `empty` = 1 after the 8th pop. A 9th pop gives `read_enable` = 0 and `fifo_error` stays 1.
- **Simultaneous push/pop**:
  - At `count` = 3: both enables 1 and `count` stays 3.
  - At `count` = 0: only the write occurs, `count` becomes 1, and `fifo_error` is set.
  - At `count` = 8: only the read occurs, `count` becomes 7, and `fifo_error` is set.
- **Wrap-around**: 20 cycles of paired push/pop at `count` = 2 → both pointers wrap 7→0 twice, data order is preserved (0x100..0x113 read back in order), and `count` stays constant at 2.
- **Thresholds**: `almost_empty_th` = 2 → `almost_empty` = 1 for `count` ≤ 2 and 0 at `count` = 3. `almost_full_th` = 0 → `almost_full` = 1 even right after reset.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for an external FIFO memory.
// Drives the memory write/read strobes and addresses; holds no data itself.
module fifo_ctrl #(
  parameter int MEM_LENGHT = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [3:0]            almost_full_th,
  input  logic [3:0]            almost_empty_th,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [4:0]            occupancy,
  output logic                  fifo_error
);

  localparam int         PTR_W = (MEM_LENGHT > 1) ? $clog2(MEM_LENGHT) : 1;
  localparam logic [4:0] DEPTH = 5'(MEM_LENGHT);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       count;
  logic             push_ok;
  logic             pop_ok;

  // Flags come from the registered count only, so acceptance never loops
  // back through the request inputs.
  assign full         = (count == DEPTH);
  assign empty        = (count == 5'd0);
  assign almost_full  = (count >= {1'b0, almost_full_th});
  assign almost_empty = ({1'b0, almost_empty_th} >= DEPTH) ||
                        (count <= {1'b0, almost_empty_th});
  assign occupancy    = count;

  // A push on full or pop on empty is refused even if the other side is
  // accepted this cycle; that keeps read and write off the same address.
  assign push_ok = push && !full  && !reset;
  assign pop_ok  = pop  && !empty && !reset;

  assign write_enable = push_ok;
  assign read_enable  = pop_ok;
  assign write_addr   = ADDR_WIDTH'(wr_ptr);
  assign read_addr    = ADDR_WIDTH'(rd_ptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_error <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase

      if ((push && full) || (pop && empty)) fifo_error <= 1'b1;

      // Memory read is registered, so valid data appears one cycle after the strobe.
      data_valid <= pop_ok;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a behavioural memory plus a reference
// occupancy model and a data scoreboard queue.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [3:0] almost_full_th = 4'd6;
  logic [3:0] almost_empty_th = 4'd2;
  logic       write_enable, read_enable, data_valid;
  logic [3:0] write_addr, read_addr;
  logic       full, empty, almost_full, almost_empty, fifo_error;
  logic [4:0] occupancy;

  logic [9:0] din = '0;
  logic [9:0] dout;
  logic [9:0] mem [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_count = 0;
  logic [2:0] m_wr = '0;
  logic [2:0] m_rd = '0;
  logic       m_err = 1'b0;
  logic       m_dv = 1'b0;
  logic [9:0] exp_q [$];

  // Values observed in the most recent step, used by the wrap-around test
  logic       obs_we, obs_re;
  logic [3:0] obs_wa, obs_ra;

  always #5 clk = ~clk;

  fifo_ctrl #(.MEM_LENGHT(8), .ADDR_WIDTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .pop             (pop),
    .almost_full_th  (almost_full_th),
    .almost_empty_th (almost_empty_th),
    .write_enable    (write_enable),
    .write_addr      (write_addr),
    .read_enable     (read_enable),
    .read_addr       (read_addr),
    .data_valid      (data_valid),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .occupancy       (occupancy),
    .fifo_error      (fifo_error)
  );

  // Behavioural 10-bit memory with a registered read port; never cleared.
  always @(posedge clk) begin
    if (write_enable) mem[write_addr] <= din;
    if (read_enable)  dout <= mem[read_addr];
  end

  // One clock of stimulus: checks strobes/flags against the model before the
  // edge, retires scoreboard data on data_valid, then advances the model.
  task automatic step(input logic p, input logic q, input logic [9:0] d);
    logic       exp_we, exp_re, exp_af, exp_ae;
    logic [9:0] want;
    push = p; pop = q; din = d;
    exp_we = p && (m_count != 8);
    exp_re = q && (m_count != 0);
    exp_af = (m_count >= int'(almost_full_th));
    exp_ae = (int'(almost_empty_th) >= 8) || (m_count <= int'(almost_empty_th));
    @(negedge clk);
    obs_we = write_enable; obs_re = read_enable; obs_wa = write_addr; obs_ra = read_addr;
    n_checks += 10;
    if (write_enable !== exp_we) begin n_fail++; $display("FAIL write_enable: got %b want %b", write_enable, exp_we); end
    if (read_enable !== exp_re) begin n_fail++; $display("FAIL read_enable: got %b want %b", read_enable, exp_re); end
    if (write_addr !== {1'b0, m_wr}) begin n_fail++; $display("FAIL write_addr: got %0d want %0d", write_addr, m_wr); end
    if (read_addr !== {1'b0, m_rd}) begin n_fail++; $display("FAIL read_addr: got %0d want %0d", read_addr, m_rd); end
    if (occupancy !== 5'(m_count)) begin n_fail++; $display("FAIL occupancy: got %0d want %0d", occupancy, m_count); end
    if (full !== (m_count == 8)) begin n_fail++; $display("FAIL full: got %b at count %0d", full, m_count); end
    if (empty !== (m_count == 0)) begin n_fail++; $display("FAIL empty: got %b at count %0d", empty, m_count); end
    if (almost_full !== exp_af) begin n_fail++; $display("FAIL almost_full: got %b want %b", almost_full, exp_af); end
    if (almost_empty !== exp_ae) begin n_fail++; $display("FAIL almost_empty: got %b want %b", almost_empty, exp_ae); end
    if ({fifo_error, data_valid} !== {m_err, m_dv}) begin
      n_fail++; $display("FAIL error_valid: got %b%b want %b%b", fifo_error, data_valid, m_err, m_dv);
    end
    if (data_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL rd_data: got %h with scoreboard empty", dout);
      end else begin
        want = exp_q.pop_front();
        if (dout !== want) begin n_fail++; $display("FAIL rd_data: got %h want %h", dout, want); end
      end
    end
    if (exp_we) exp_q.push_back(d);
    @(posedge clk); #1;
    if (exp_we) m_wr = m_wr + 3'd1;
    if (exp_re) m_rd = m_rd + 3'd1;
    m_count = m_count + int'(exp_we) - int'(exp_re);
    m_err   = m_err | (p && !exp_we) | (q && !exp_re);
    m_dv    = exp_re;
    push = 1'b0; pop = 1'b0;
  endtask

  // Asynchronous reset with requests held high; outputs must clear at once.
  task automatic apply_reset();
    push = 1'b1; pop = 1'b1; reset = 1'b1;
    #2;
    n_checks += 6;
    if ({occupancy, empty, full} !== 7'b00000_1_0) begin
      n_fail++; $display("FAIL rst_count: occ=%0d empty=%b full=%b want 0/1/0", occupancy, empty, full);
    end
    if ({write_addr, read_addr} !== 8'h00) begin
      n_fail++; $display("FAIL rst_addr: wa=%0d ra=%0d want 0/0", write_addr, read_addr);
    end
    if ({write_enable, read_enable} !== 2'b00) begin
      n_fail++; $display("FAIL rst_enables: got %b%b want 00", write_enable, read_enable);
    end
    if ({data_valid, fifo_error} !== 2'b00) begin
      n_fail++; $display("FAIL rst_dv_err: got %b%b want 00", data_valid, fifo_error);
    end
    if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_almost_empty: got %b want 1", almost_empty); end
    if (almost_full !== (almost_full_th == 4'd0)) begin
      n_fail++; $display("FAIL rst_almost_full: got %b with th %0d", almost_full, almost_full_th);
    end
    @(negedge clk);
    reset = 1'b0; push = 1'b0; pop = 1'b0;
    @(posedge clk); #1;
    m_count = 0; m_wr = '0; m_rd = '0; m_err = 1'b0; m_dv = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 10'h030 + 10'(i));
    step(1'b0, 1'b1, '0);
    n_checks++;
    if ({occupancy, data_valid} !== {5'd5, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset: occ=%0d dv=%b want 5/1", occupancy, data_valid);
    end
    apply_reset();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 10'(i));
      n_checks++;
      if ({almost_full, full} !== {i >= 6, i == 8}) begin
        n_fail++; $display("FAIL fill_flags[%0d]: got af=%b full=%b", i, almost_full, full);
      end
    end
    step(1'b1, 1'b0, 10'h3ff);
    n_checks++;
    if ({fifo_error, occupancy} !== {1'b1, 5'd8}) begin
      n_fail++; $display("FAIL overflow: err=%b occ=%0d want 1/8", fifo_error, occupancy);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (obs_ra !== 4'(i)) begin n_fail++; $display("FAIL drain_addr: got %0d want %0d", obs_ra, i); end
    end
    step(1'b0, 1'b1, '0);
    n_checks++;
    if ({obs_re, empty, fifo_error} !== 3'b011) begin
      n_fail++; $display("FAIL underflow: re=%b empty=%b err=%b want 0/1/1", obs_re, empty, fifo_error);
    end
    step(1'b0, 1'b0, '0);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h020 + 10'(i));
    step(1'b1, 1'b1, 10'h023);
    n_checks++;
    if ({obs_we, obs_re, occupancy, fifo_error} !== {2'b11, 5'd3, 1'b0}) begin
      n_fail++; $display("FAIL simul_mid: we=%b re=%b occ=%0d err=%b", obs_we, obs_re, occupancy, fifo_error);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 10'h024);
    n_checks++;
    if ({obs_we, obs_re, occupancy, fifo_error} !== {2'b10, 5'd1, 1'b1}) begin
      n_fail++; $display("FAIL simul_empty: we=%b re=%b occ=%0d err=%b", obs_we, obs_re, occupancy, fifo_error);
    end
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h040 + 10'(i));
    step(1'b1, 1'b1, 10'h0ff);
    n_checks++;
    if ({obs_we, obs_re, occupancy, fifo_error} !== {2'b01, 5'd7, 1'b1}) begin
      n_fail++; $display("FAIL simul_full: we=%b re=%b occ=%0d err=%b", obs_we, obs_re, occupancy, fifo_error);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
  endtask

  task automatic test_wrap();
    int wr_wraps, rd_wraps;
    wr_wraps = 0; rd_wraps = 0;
    apply_reset();
    step(1'b1, 1'b0, 10'h0fe);
    step(1'b1, 1'b0, 10'h0ff);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 10'h100 + 10'(i));
      if (obs_we && obs_wa == 4'd7) wr_wraps++;
      if (obs_re && obs_ra == 4'd7) rd_wraps++;
      n_checks++;
      if (occupancy !== 5'd2) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 2", i, occupancy); end
    end
    n_checks++;
    if (wr_wraps != 2 || rd_wraps != 2) begin
      n_fail++; $display("FAIL wrap_ptrs: wr=%0d rd=%0d want 2/2", wr_wraps, rd_wraps);
    end
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain: %0d entries left, want 0", exp_q.size()); end
  endtask

  task automatic test_thresholds();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 10'(i));
      n_checks++;
      if (almost_empty !== (i <= 2)) begin
        n_fail++; $display("FAIL ae_th2[%0d]: got %b want %b", i, almost_empty, i <= 2);
      end
    end
    almost_empty_th = 4'd15; #1;
    n_checks++;
    if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL ae_th15: got %b want 1", almost_empty); end
    almost_empty_th = 4'd2;
    almost_full_th = 4'd0;
    apply_reset();
    n_checks++;
    if (almost_full !== 1'b1) begin n_fail++; $display("FAIL af_th0: got %b want 1", almost_full); end
    step(1'b1, 1'b0, 10'h055);
    almost_full_th = 4'd6;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_thresholds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
